// File: rtl/acp_pkg.sv
// Shared definitions for the ACP MM2S datamover engine: command field
// positions, status layout, FSM encoding and beat/page constants.
package acp_pkg;

  // Command stream field positions
  localparam int unsigned CMD_W     = 72;
  localparam int unsigned BTT_LSB   = 0;
  localparam int unsigned BTT_MSB   = 22;
  localparam int unsigned TYPE_BIT  = 23;
  localparam int unsigned EOF_BIT   = 30;
  localparam int unsigned SADDR_LSB = 32;
  localparam int unsigned SADDR_MSB = 63;
  localparam int unsigned TAG_LSB   = 64;
  localparam int unsigned TAG_MSB   = 67;

  localparam int unsigned BTT_W   = BTT_MSB - BTT_LSB + 1;
  localparam int unsigned SADDR_W = SADDR_MSB - SADDR_LSB + 1;
  localparam int unsigned TAG_W   = TAG_MSB - TAG_LSB + 1;

  // Status word bit indices
  localparam int unsigned STS_W          = 8;
  localparam int unsigned STS_TAG_LSB    = 0;
  localparam int unsigned STS_INTERR_BIT = 4;
  localparam int unsigned STS_DECERR_BIT = 5;
  localparam int unsigned STS_SLVERR_BIT = 6;
  localparam int unsigned STS_OK_BIT     = 7;

  // Beat and page geometry
  localparam int unsigned ACP_BEAT_BYTES  = 8;
  localparam int unsigned ACP_4K_BOUNDARY = 4096;
  localparam int unsigned BEAT_SHIFT      = 3;
  localparam int unsigned BEATS_W         = BTT_W - BEAT_SHIFT;
  localparam int unsigned BURST_W         = 5;
  localparam int unsigned PAGE_IDX_W      = 9;
  localparam int unsigned PAGE_BEATS_W    = 10;
  localparam int unsigned ARLEN_W         = 8;

  // Status payload, field order matches the bit indices above
  typedef struct packed {
    logic             ok;
    logic             slverr;
    logic             decerr;
    logic             interr;
    logic [TAG_W-1:0] tag;
  } sts_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_STS   = 3'd4
  } state_e;

endpackage

// File: rtl/acp_burst_calc.sv
// Burst sizing: beats = min(remaining, max burst length, beats left in 4 KB page).
module acp_burst_calc
  import acp_pkg::*;
#(
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic [BEATS_W-1:0]    remaining,
  input  logic [PAGE_IDX_W-1:0] page_beat,
  output logic [BURST_W-1:0]    beats,
  output logic [ARLEN_W-1:0]    arlen
);

  localparam int unsigned PAGE_BEATS = ACP_4K_BOUNDARY / ACP_BEAT_BYTES;

  logic [PAGE_BEATS_W-1:0] to_page;
  logic [BEATS_W-1:0]      lim;

  // Three-way minimum; remaining is never zero when the result is used
  always_comb begin
    to_page = PAGE_BEATS_W'(PAGE_BEATS) - PAGE_BEATS_W'(page_beat);
    lim     = BEATS_W'(MAX_BURST_LEN);
    if (remaining < lim) lim = remaining;
    if (BEATS_W'(to_page) < lim) lim = BEATS_W'(to_page);
    beats = BURST_W'(lim);
    arlen = ARLEN_W'(beats) - ARLEN_W'(1);
  end

endmodule

// File: rtl/acp_mm2s_engine.sv
// MM2S datamover engine: takes one read command, issues 4 KB-safe INCR bursts
// on the ACP read port, forwards read data as a stream, returns a status byte.
// Optional macro ACP_MM2S_BYTE_SWAP_EN byte-reverses the forwarded stream data.
module acp_mm2s_engine
  import acp_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_MAX_BURST_LEN    = 16,
  parameter logic [3:0]  C_ARCACHE          = 4'b1111,
  parameter logic [2:0]  C_PROT             = 3'b010
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic                            S_AXIS_CMD_TVALID,
  output logic                            S_AXIS_CMD_TREADY,
  input  logic [71:0]                     S_AXIS_CMD_TDATA,
  output logic                            M_AXIS_STS_TVALID,
  input  logic                            M_AXIS_STS_TREADY,
  output logic [7:0]                      M_AXIS_STS_TDATA,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY
);

  localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DATA_W = C_M_AXI_DATA_WIDTH;
  localparam int unsigned KEEP_W = DATA_W / 8;

  state_e state, next_state;

  logic                cmd_ready;
  logic                sts_valid;
  logic [BTT_W-1:0]    btt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BEATS_W-1:0]  remaining_q;
  logic [TAG_W-1:0]    tag_q;
  logic                eof_q;
  logic                type_q;
  logic                interr_q;
  logic                slverr_q;
  logic                decerr_q;

  logic                interr_c;
  logic                r_hs_c;
  logic [BURST_W-1:0]  burst_beats_c;
  logic [ARLEN_W-1:0]  burst_arlen_c;
  logic [DATA_W-1:0]   stream_data_c;
  sts_t                sts_c;
  logic                unused_cmd_bits;

  assign unused_cmd_bits = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[31],
                             S_AXIS_CMD_TDATA[29:24]};

  acp_burst_calc #(
    .MAX_BURST_LEN (C_MAX_BURST_LEN)
  ) u_burst_calc (
    .remaining (remaining_q),
    .page_beat (addr_q[11:3]),
    .beats     (burst_beats_c),
    .arlen     (burst_arlen_c)
  );

  // Command sanity: zero length, partial beat, misaligned address or fixed type
  assign interr_c = (btt_q == '0) || (btt_q[2:0] != 3'b000) ||
                    (addr_q[2:0] != 3'b000) || !type_q;

  assign r_hs_c = (state == ST_DATA) && M_AXI_RVALID && M_AXIS_TREADY;

  // Stream data ordering
`ifdef ACP_MM2S_BYTE_SWAP_EN
  always_comb begin
    stream_data_c = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      stream_data_c[i*8 +: 8] = M_AXI_RDATA[(KEEP_W-1-i)*8 +: 8];
    end
  end
`else
  always_comb begin
    stream_data_c = M_AXI_RDATA;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state decode and combinational channel outputs
  always_comb begin
    next_state    = state;
    M_AXI_ARVALID = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARLEN   = '0;
    M_AXI_RREADY  = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (S_AXIS_CMD_TVALID && cmd_ready) next_state = ST_CHECK;
      end
      ST_CHECK: begin
        next_state = interr_c ? ST_STS : ST_ADDR;
      end
      ST_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = addr_q;
        M_AXI_ARLEN   = burst_arlen_c;
        if (M_AXI_ARREADY) next_state = ST_DATA;
      end
      ST_DATA: begin
        M_AXI_RREADY  = M_AXIS_TREADY;
        M_AXIS_TVALID = M_AXI_RVALID;
        M_AXIS_TDATA  = stream_data_c;
        M_AXIS_TLAST  = eof_q && M_AXI_RLAST && (remaining_q == '0);
        if (r_hs_c && M_AXI_RLAST) begin
          next_state = (remaining_q != '0) ? ST_ADDR : ST_STS;
        end
      end
      ST_STS: begin
        if (M_AXIS_STS_TREADY && sts_valid) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Command latch, burst bookkeeping, sticky errors and registered handshakes
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_ready   <= 1'b0;
      sts_valid   <= 1'b0;
      btt_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      tag_q       <= '0;
      eof_q       <= 1'b0;
      type_q      <= 1'b0;
      interr_q    <= 1'b0;
      slverr_q    <= 1'b0;
      decerr_q    <= 1'b0;
    end else begin
      cmd_ready <= (next_state == ST_IDLE);
      sts_valid <= (next_state == ST_STS);
      unique case (state)
        ST_IDLE: begin
          if (S_AXIS_CMD_TVALID && cmd_ready) begin
            btt_q  <= S_AXIS_CMD_TDATA[BTT_MSB:BTT_LSB];
            addr_q <= ADDR_W'(S_AXIS_CMD_TDATA[SADDR_MSB:SADDR_LSB]);
            tag_q  <= S_AXIS_CMD_TDATA[TAG_MSB:TAG_LSB];
            eof_q  <= S_AXIS_CMD_TDATA[EOF_BIT];
            type_q <= S_AXIS_CMD_TDATA[TYPE_BIT];
          end
        end
        ST_CHECK: begin
          if (interr_c) interr_q    <= 1'b1;
          else          remaining_q <= btt_q[BTT_W-1:BEAT_SHIFT];
        end
        ST_ADDR: begin
          if (M_AXI_ARREADY) begin
            addr_q      <= addr_q + (ADDR_W'(burst_beats_c) << BEAT_SHIFT);
            remaining_q <= remaining_q - BEATS_W'(burst_beats_c);
          end
        end
        ST_DATA: begin
          if (r_hs_c) begin
            if (M_AXI_RRESP == 2'b10) slverr_q <= 1'b1;
            if (M_AXI_RRESP == 2'b11) decerr_q <= 1'b1;
          end
        end
        ST_STS: begin
          if (M_AXIS_STS_TREADY && sts_valid) begin
            interr_q <= 1'b0;
            slverr_q <= 1'b0;
            decerr_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Status word assembly
  always_comb begin
    sts_c.tag    = tag_q;
    sts_c.interr = interr_q;
    sts_c.decerr = decerr_q;
    sts_c.slverr = slverr_q;
    sts_c.ok     = !(interr_q || decerr_q || slverr_q);
  end

  assign S_AXIS_CMD_TREADY = cmd_ready;
  assign M_AXIS_STS_TVALID = sts_valid;
  assign M_AXIS_STS_TDATA  = sts_valid ? sts_c : '0;
  assign M_AXI_ARSIZE      = 3'b011;
  assign M_AXI_ARBURST     = 2'b01;
  assign M_AXI_ARCACHE     = C_ARCACHE;
  assign M_AXI_ARPROT      = C_PROT;
  assign M_AXIS_TKEEP      = {KEEP_W{1'b1}};

endmodule

// File: tb/tb_acp_mm2s_engine.sv
// Directed bench for acp_mm2s_engine with an ACP read-slave model and stream sink.
module tb_acp_mm2s_engine;

  logic        clk;
  logic        aresetn;
  logic        S_AXIS_CMD_TVALID;
  logic        S_AXIS_CMD_TREADY;
  logic [71:0] S_AXIS_CMD_TDATA;
  logic        M_AXIS_STS_TVALID;
  logic        M_AXIS_STS_TREADY;
  logic [7:0]  M_AXIS_STS_TDATA;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [63:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [63:0] M_AXIS_TDATA;
  logic [7:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;

  acp_mm2s_engine dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .S_AXIS_CMD_TVALID (S_AXIS_CMD_TVALID),
    .S_AXIS_CMD_TREADY (S_AXIS_CMD_TREADY),
    .S_AXIS_CMD_TDATA  (S_AXIS_CMD_TDATA),
    .M_AXIS_STS_TVALID (M_AXIS_STS_TVALID),
    .M_AXIS_STS_TREADY (M_AXIS_STS_TREADY),
    .M_AXIS_STS_TDATA  (M_AXIS_STS_TDATA),
    .M_AXI_ARADDR      (M_AXI_ARADDR),
    .M_AXI_ARLEN       (M_AXI_ARLEN),
    .M_AXI_ARSIZE      (M_AXI_ARSIZE),
    .M_AXI_ARBURST     (M_AXI_ARBURST),
    .M_AXI_ARCACHE     (M_AXI_ARCACHE),
    .M_AXI_ARPROT      (M_AXI_ARPROT),
    .M_AXI_ARVALID     (M_AXI_ARVALID),
    .M_AXI_ARREADY     (M_AXI_ARREADY),
    .M_AXI_RDATA       (M_AXI_RDATA),
    .M_AXI_RRESP       (M_AXI_RRESP),
    .M_AXI_RLAST       (M_AXI_RLAST),
    .M_AXI_RVALID      (M_AXI_RVALID),
    .M_AXI_RREADY      (M_AXI_RREADY),
    .M_AXIS_TDATA      (M_AXIS_TDATA),
    .M_AXIS_TKEEP      (M_AXIS_TKEEP),
    .M_AXIS_TLAST      (M_AXIS_TLAST),
    .M_AXIS_TVALID     (M_AXIS_TVALID),
    .M_AXIS_TREADY     (M_AXIS_TREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Written only by the main sequence
  bit rand_mode = 1'b0;
  int err_beat  = -1;

  // Written only by the slave model / sink
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [63:0] s_data[$];
  logic        s_last[$];
  int          beat_idx = 0;
  int          ar_valid_cycles = 0;
  bit          r_active = 1'b0;
  logic [31:0] r_addr = '0;
  int          r_left = 0;
  int          ar_wait = 0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  function automatic logic [71:0] mk_cmd(input logic [22:0] btt, input logic typ,
                                         input logic eof, input logic [31:0] saddr,
                                         input logic [3:0] tag);
    logic [71:0] c;
    c = '0;
    c[22:0]  = btt;
    c[23]    = typ;
    c[30]    = eof;
    c[63:32] = saddr;
    c[67:64] = tag;
    return c;
  endfunction

  function automatic logic [31:0] ar_a(input int i);
    return (i < ar_addr_q.size()) ? ar_addr_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] ar_l(input int i);
    return (i < ar_len_q.size()) ? ar_len_q[i] : 8'hEE;
  endfunction

  // ACP read slave and stream sink: drive at negedge, then log the handshakes
  // that the following posedge will complete
  always @(negedge clk) begin
    if (!aresetn) begin
      r_active      = 1'b0;
      r_left        = 0;
      ar_wait       = 0;
      M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID  = 1'b0;
      M_AXI_RLAST   = 1'b0;
      M_AXI_RDATA   = '0;
      M_AXI_RRESP   = 2'b00;
      M_AXIS_TREADY = 1'b0;
    end else begin
      M_AXIS_TREADY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXI_ARREADY = (ar_wait == 0);
      M_AXI_RVALID  = r_active;
      M_AXI_RDATA   = r_active ? mem_word(r_addr) : 64'h0;
      M_AXI_RLAST   = r_active && (r_left == 1);
      M_AXI_RRESP   = (r_active && beat_idx == err_beat) ? 2'b10 : 2'b00;
      #1;
      if (aresetn) begin
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          s_data.push_back(M_AXIS_TDATA);
          s_last.push_back(M_AXIS_TLAST);
        end
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          beat_idx++;
          r_addr = r_addr + 32'd8;
          r_left--;
          if (r_left == 0) r_active = 1'b0;
        end
        if (M_AXI_ARVALID) ar_valid_cycles++;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          ar_addr_q.push_back(M_AXI_ARADDR);
          ar_len_q.push_back(M_AXI_ARLEN);
          r_active = 1'b1;
          r_addr   = M_AXI_ARADDR;
          r_left   = int'(M_AXI_ARLEN) + 1;
          ar_wait  = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end else if (M_AXI_ARVALID && ar_wait > 0) begin
          ar_wait--;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input string tag, input logic [71:0] c);
    int n;
    n = 0;
    @(negedge clk);
    S_AXIS_CMD_TDATA  = c;
    S_AXIS_CMD_TVALID = 1'b1;
    while (!S_AXIS_CMD_TREADY && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cmd_accepted"}, 64'(n < 100), 64'd1);
    @(negedge clk);
    S_AXIS_CMD_TVALID = 1'b0;
  endtask

  task automatic wait_sts(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!M_AXIS_STS_TVALID && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sts_valid"}, 64'(M_AXIS_STS_TVALID), 64'd1);
    chk({tag, "_sts_data"}, 64'(M_AXIS_STS_TDATA), 64'(exp));
    M_AXIS_STS_TREADY = 1'b1;
    @(negedge clk);
    M_AXIS_STS_TREADY = 1'b0;
    chk({tag, "_sts_drop"}, 64'(M_AXIS_STS_TVALID), 64'd0);
  endtask

  task automatic check_stream(input string tag, input int base, input logic [31:0] saddr,
                              input int nbeats, input bit eof);
    int bad_d;
    int bad_l;
    bad_d = 0;
    bad_l = 0;
    chk({tag, "_beats"}, 64'(s_data.size() - base), 64'(nbeats));
    for (int k = 0; k < nbeats && (base + k) < s_data.size(); k++) begin
      if (s_data[base+k] !== mem_word(saddr + 32'(k * 8))) bad_d++;
      if (s_last[base+k] !== 1'(eof && (k == nbeats - 1))) bad_l++;
    end
    chk({tag, "_data_errs"}, 64'(bad_d), 64'd0);
    chk({tag, "_tlast_errs"}, 64'(bad_l), 64'd0);
  endtask

  initial begin
    int sb;
    int ab;
    int vb;
    int n;
    int seen;

    aresetn           = 1'b0;
    S_AXIS_CMD_TVALID = 1'b0;
    S_AXIS_CMD_TDATA  = '0;
    M_AXIS_STS_TREADY = 1'b0;

    // Reset state
    @(negedge clk);
    #2;
    chk("rst_cmd_tready", 64'(S_AXIS_CMD_TREADY), 64'd0);
    chk("rst_arvalid", 64'(M_AXI_ARVALID), 64'd0);
    chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_sts_tvalid", 64'(M_AXIS_STS_TVALID), 64'd0);
    chk("const_ar", 64'({M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_ARPROT}),
        64'({3'b011, 2'b01, 4'b1111, 3'b010}));
    chk("const_tkeep", 64'(M_AXIS_TKEEP), 64'hFF);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("idle_cmd_tready", 64'(S_AXIS_CMD_TREADY), 64'd1);

    // Single aligned burst with EOF
    sb = s_data.size(); ab = ar_addr_q.size();
    send_cmd("t1", mk_cmd(23'd64, 1'b1, 1'b1, 32'h0000_1000, 4'd5));
    wait_sts("t1", 8'h85);
    chk("t1_ar_count", 64'(ar_addr_q.size() - ab), 64'd1);
    chk("t1_araddr", 64'(ar_a(ab)), 64'h1000);
    chk("t1_arlen", 64'(ar_l(ab)), 64'd7);
    check_stream("t1", sb, 32'h0000_1000, 8, 1'b1);

    // 4 KB split and max-length split
    sb = s_data.size(); ab = ar_addr_q.size();
    send_cmd("t2", mk_cmd(23'd200, 1'b1, 1'b1, 32'h0000_0FF0, 4'd1));
    wait_sts("t2", 8'h81);
    chk("t2_ar_count", 64'(ar_addr_q.size() - ab), 64'd3);
    chk("t2_ar0", 64'({ar_a(ab), ar_l(ab)}), 64'({32'h0FF0, 8'd1}));
    chk("t2_ar1", 64'({ar_a(ab+1), ar_l(ab+1)}), 64'({32'h1000, 8'd15}));
    chk("t2_ar2", 64'({ar_a(ab+2), ar_l(ab+2)}), 64'({32'h1080, 8'd6}));
    check_stream("t2", sb, 32'h0000_0FF0, 25, 1'b1);

    // Partial-beat length: internal error, no AXI traffic
    sb = s_data.size(); vb = ar_valid_cycles;
    send_cmd("t3", mk_cmd(23'd12, 1'b1, 1'b1, 32'h0000_2000, 4'd3));
    wait_sts("t3", 8'h13);
    chk("t3_arvalid_cycles", 64'(ar_valid_cycles - vb), 64'd0);
    chk("t3_beats", 64'(s_data.size() - sb), 64'd0);

    // Fixed-address type: internal error
    vb = ar_valid_cycles;
    send_cmd("t3b", mk_cmd(23'd64, 1'b0, 1'b1, 32'h0000_2000, 4'd6));
    wait_sts("t3b", 8'h16);
    chk("t3b_arvalid_cycles", 64'(ar_valid_cycles - vb), 64'd0);

    // SLVERR on second beat, transfer continues
    sb = s_data.size();
    err_beat = beat_idx + 1;
    send_cmd("t4", mk_cmd(23'd32, 1'b1, 1'b1, 32'h0000_2000, 4'd7));
    wait_sts("t4", 8'h47);
    err_beat = -1;
    check_stream("t4", sb, 32'h0000_2000, 4, 1'b1);

    // Random back-pressure, EOF clear
    sb = s_data.size(); ab = ar_addr_q.size();
    rand_mode = 1'b1;
    send_cmd("t5", mk_cmd(23'd256, 1'b1, 1'b0, 32'h0000_3000, 4'd9));
    wait_sts("t5", 8'h89);
    rand_mode = 1'b0;
    chk("t5_ar0", 64'({ar_a(ab), ar_l(ab)}), 64'({32'h3000, 8'd15}));
    chk("t5_ar1", 64'({ar_a(ab+1), ar_l(ab+1)}), 64'({32'h3080, 8'd15}));
    check_stream("t5", sb, 32'h0000_3000, 32, 1'b0);

    // Reset in the middle of a data burst
    sb = s_data.size();
    send_cmd("t6", mk_cmd(23'd128, 1'b1, 1'b1, 32'h0000_4000, 4'd2));
    n = 0;
    while ((s_data.size() - sb) < 3 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t6_reached_data", 64'(n < 200), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_outputs", 64'({M_AXI_ARVALID, M_AXI_RREADY, M_AXIS_TVALID, M_AXIS_TLAST,
                               M_AXIS_STS_TVALID, S_AXIS_CMD_TREADY}), 64'd0);
    chk("t6_rst_tdata", M_AXIS_TDATA, 64'd0);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (M_AXIS_STS_TVALID) seen++;
    end
    chk("t6_no_stale_sts", 64'(seen), 64'd0);
    sb = s_data.size(); ab = ar_addr_q.size();
    send_cmd("t6b", mk_cmd(23'd16, 1'b1, 1'b1, 32'h0000_5000, 4'd4));
    wait_sts("t6b", 8'h84);
    chk("t6b_ar0", 64'({ar_a(ab), ar_l(ab)}), 64'({32'h5000, 8'd1}));
    check_stream("t6b", sb, 32'h0000_5000, 2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acp_mm2s_engine.md
Name: acp_mm2s_engine

Overview:
- Responder for the 72-bit datamover command stream produced by axi4_stream_master (h2s direction); in-house replacement for the MM2S half of xlnx_axi_datamover.
- Accepts one read command, splits it into AXI4 INCR bursts on the ACP read port, and forwards read data as an AXI4-Stream.
- Returns one 8-bit status word per command.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, ACP address width.
- C_M_AXI_DATA_WIDTH, 64, ACP/stream data width; fixed 64 (8-byte beats).
- C_MAX_BURST_LEN, 16, maximum beats per burst; power of 2, range 1..16.
- C_ARCACHE, 4'b1111, ARCACHE value driven on every burst.
- C_PROT, 3'b010, ARPROT value driven on every burst.

Ports:
- clk  in  1  clock
- aresetn  in  1  async active-low reset
- S_AXIS_CMD_TVALID  in  1  command valid
- S_AXIS_CMD_TREADY  out  1  command ready
- S_AXIS_CMD_TDATA  in  72  [22:0] BTT, [23] TYPE, [30] EOF, [63:32] SADDR, [67:64] TAG; other bits ignored
- M_AXIS_STS_TVALID  out  1  status valid
- M_AXIS_STS_TREADY  in  1  status ready
- M_AXIS_STS_TDATA  out  8  [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR, [7] OK
- M_AXI_ARADDR  out  32  burst address
- M_AXI_ARLEN  out  8  beats-1
- M_AXI_ARSIZE  out  3  constant 3'b011
- M_AXI_ARBURST  out  2  constant 2'b01
- M_AXI_ARCACHE  out  4  C_ARCACHE
- M_AXI_ARPROT  out  3  C_PROT
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARREADY  in  1  address ready
- M_AXI_RDATA  in  64  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RLAST  in  1  last beat of burst
- M_AXI_RVALID  in  1  read valid
- M_AXI_RREADY  out  1  read ready
- M_AXIS_TDATA  out  64  stream data
- M_AXIS_TKEEP  out  8  constant 8'hff
- M_AXIS_TLAST  out  1  last beat of command when EOF=1
- M_AXIS_TVALID  out  1  stream valid
- M_AXIS_TREADY  in  1  stream ready

Behaviour:
- Reset (async assert, sync deassert usage): FSM to IDLE; all valids 0, S_AXIS_CMD_TREADY 0, status regs 0.
- States: IDLE -> CHECK -> ADDR -> DATA -> (ADDR | STS) -> IDLE.
- IDLE: CMD_TREADY=1; on handshake, latch BTT, SADDR, TAG, EOF, TYPE; go to CHECK next cycle. CMD_TREADY=0 in every other state.
- CHECK (1 cycle): INTERR if BTT==0, BTT[2:0]!=0, SADDR[2:0]!=0, or TYPE==0. On INTERR: no AXI traffic, go to STS. Otherwise remaining_beats = BTT>>3, go to ADDR.
- ADDR: ARVALID=1 held stable until ARREADY.
  - beats = min(remaining_beats, C_MAX_BURST_LEN, beats to next 4 KB boundary).
  - ARLEN = beats-1.
  - On handshake: addr += beats*8; remaining_beats -= beats; go to DATA.
- DATA: combinational pass-through, RREADY = M_AXIS_TREADY, TVALID = RVALID, TDATA = RDATA.
  - TLAST = EOF && RLAST && remaining_beats==0.
  - RRESP==2'b10 sets sticky SLVERR; RRESP==2'b11 sets sticky DECERR. Transfer continues regardless.
  - On RLAST handshake: go to ADDR if remaining_beats!=0, else STS.
  - Only one burst outstanding at a time.
- STS: STS_TVALID=1, TDATA={OK, SLVERR, DECERR, INTERR, TAG}, where OK = no error bit set. Hold until STS_TREADY; then clear sticky errors, go to IDLE.
- Back-pressure: TREADY low stalls RREADY indefinitely with no data loss. A STS_TREADY stall blocks the next command.
- Reset mid-transfer: abandons the burst, emits no status; the bench must also reset the ACP model.
- Throughput: 1 beat/cycle within a burst. Inter-burst gap is 1 cycle minimum (ADDR state).

Optional Feature:
- Macro: ACP_MM2S_BYTE_SWAP_EN.
- Defined: M_AXIS_TDATA is RDATA byte-reversed (byte 0 <-> byte 7, etc.).
- Undefined: TDATA = RDATA unchanged.

Decomposition:
- Package acp_pkg holds:
  - command field bit-position localparams (BTT_LSB/MSB, TYPE_BIT, EOF_BIT, SADDR_LSB/MSB, TAG_LSB/MSB);
  - status bit indices;
  - FSM state encoding;
  - constants ACP_BEAT_BYTES=8 and ACP_4K_BOUNDARY=4096.
- Sub-module acp_burst_calc: combinational beats computation (remaining, address, max-len -> beats, arlen).

Test Plan:
- BTT=64, SADDR=0x1000, EOF=1, TAG=5 -> one AR (ARLEN=7, ARADDR=0x1000); 8 stream beats; TLAST on beat 8 only; status 0x85.
- BTT=200, SADDR=0x0FF0 -> ARs: 0x0FF0 len1 (4 KB split), 0x1000 len15, 0x1080 len6; 25 beats total; status OK.
- BTT=12 (unaligned), TAG=3 -> no ARVALID ever; status 0x13.
- BTT=32 with RRESP=SLVERR on beat 2 -> all 4 beats still forwarded; status = TAG | 0x40, OK=0.
- Random TREADY (50%) and ARREADY delays on BTT=256, EOF=0 -> data matches memory model in order; TLAST never asserted.
- aresetn pulsed low mid-DATA -> all outputs 0 immediately; a new command after release completes normally.
